inv_mix_col_seq: RTL
====================

Name: inv_mix_col_seq

Overview:
- Iterative AES InvMixColumns engine for the decryption datapath; it is the inverse of the forward per-column MixColumns block used in the cipher.
- Accepts a full 128-bit state on a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Presents the 128-bit result on a valid/ready output handshake, so it sits between InvShiftRows/InvSubBytes and AddRoundKey in a multi-cycle inverse round.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; latency = 4/COLS_PER_CYCLE cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  state_in is valid this cycle.
- in_ready  output  1  block can accept a new state.
- state_in  input  128  input state; column c = state_in[127-32c -: 32]; row 0 = MSB byte of each column.
- out_valid  output  1  state_out holds a completed result.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  InvMixColumns result, same column/byte layout as state_in.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Per-column math, with input bytes a0..a3 (a0 = MSB):
  - b0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
  - b1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
  - b2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
  - b3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
- Field rules: GF(2^8) multiply with reduction polynomial 0x11B. Build the constants from xtime chains: 09=8^1, 0b=8^2^1, 0d=8^4^1, 0e=8^4^2. All results are 8 bits; no carries propagate.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch state_in into the work register, set col_cnt=0, go to RUN.
  - RUN: in_ready=0. Each edge transforms COLS_PER_CYCLE columns starting at col_cnt, writes them into the result register, and adds COLS_PER_CYCLE to col_cnt. The edge that completes column 3 goes to DONE and sets out_valid=1.
  - DONE: out_valid=1 and state_out stable. On out_ready, go to IDLE and clear out_valid on that edge. in_ready stays 0 in DONE; there is no same-cycle back-to-back acceptance.
- Latency: out_valid rises exactly 4/COLS_PER_CYCLE rising edges after the accepting edge (4 edges for the default of 1).
- Throughput: at most one state per (latency + 2) cycles when out_ready is held high.
- state_out is driven only from the result register (registered, glitch-free). After the out handshake it holds its last value until the next completion overwrites it.
- in_valid outside IDLE is ignored, and state_in changes during RUN have no effect because the input is latched.
- out_ready outside DONE is ignored.
- Reset: rst=1 at any time, including mid-RUN or in DONE, immediately forces:
  - IDLE, col_cnt=0;
  - out_valid=0, busy=0, state_out=0, internal registers=0;
  - in_ready=0 while rst is asserted, in_ready=1 on the first cycle after release.
- A partially processed state is discarded on reset. No result is produced for it.
- For COLS_PER_CYCLE not in {1,2,4}, elaboration must fail via a generate-time check.

Test Plan:
- Single column vectors (column 0, with columns 1-3 set to 00000000): 8e4da1bc -> db135345; 9fdc589d -> f20a225c; 4d7ebdf8 -> 2d26314c; d5d5d7d6 -> d4d4d4d5; 01010101 -> 01010101; c6c6c6c6 -> c6c6c6c6.
- Full state: state_in=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> state_out=db135345_f20a225c_01010101_c6c6c6c6; out_valid rises exactly 4 edges after acceptance (2 edges with COLS_PER_CYCLE=2, 1 edge with 4).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_valid and state_out stable, in_ready=0, in_valid pulses ignored. Then raise out_ready: IDLE and in_ready=1 on the next cycle.
- Round trip: 1000 random 128-bit states passed through four forward mix_col instances, then this block -> output equals the original state. Also the reverse order (this block, then forward) -> identity.
- Reset mid-operation: assert rst during RUN after 2 columns -> out_valid=0, state_out=0, busy=0 immediately. After release, a new state 4d7ebdf8_... is processed correctly with no residue from the aborted state.
- Protocol: in_valid held high continuously with out_ready=1 -> exactly one acceptance per 6 cycles (COLS_PER_CYCLE=1), and each output matches its corresponding input.

Source files
------------

// File: rtl/inv_mix_col_seq.sv
// Iterative AES InvMixColumns engine: latches a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock, and holds the result on a valid/ready output.

module inv_mix_col_lane (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Constants built from the xtime chain: 09=8^1, 0b=8^2^1, 0d=8^4^1, 0e=8^4^2.
  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_in;

  assign col_out = {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
                    m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
                    md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
                    mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
endmodule

module inv_mix_col_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("inv_mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
  st_t st_q, st_d;

  // Packed column arrays: index 3 is column 0 (MSB word).
  logic [3:0][31:0] work_q, res_q;
  logic [2:0]       col_cnt;

  logic [COLS_PER_CYCLE-1:0][31:0] lane_in, lane_out;
  logic [COLS_PER_CYCLE-1:0][1:0]  lane_ridx;

  for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
    assign lane_ridx[l] = ~(col_cnt[1:0] + 2'(l));
    assign lane_in[l]   = work_q[lane_ridx[l]];
    inv_mix_col_lane u_lane (.col_in(lane_in[l]), .col_out(lane_out[l]));
  end

  assign in_ready  = (st_q == IDLE) && !rst;
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q != IDLE);
  assign state_out = res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (in_valid) st_d = RUN;
      RUN:     if (col_cnt + STEP == 3'd4) st_d = DONE;
      DONE:    if (out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q  <= '0;
      res_q   <= '0;
      col_cnt <= '0;
    end else begin
      case (st_q)
        IDLE: if (in_valid) begin
          work_q  <= state_in;
          col_cnt <= '0;
        end
        RUN: begin
          for (int l = 0; l < COLS_PER_CYCLE; l++) res_q[lane_ridx[l]] <= lane_out[l];
          col_cnt <= col_cnt + STEP;
        end
        default: ;
      endcase
    end
  end
endmodule
